vmem_slot_sched: RTL and testbench

Dynamic time-slot scheduler for the video memory phase engine. It replaces the static 8-entry slot table with per-slot arbitration between four address sources, and emits one slot word per 4-phase memory cycle. Slots flagged in a reserved mask belong to source 0 (display scanout); all other slots are round-robin. The reserved mask is run-time configurable and takes effect only at frame boundaries.

---
 rtl/vmem_pkg.sv | 48 ++++
 rtl/vmem_slot_sched_if.sv | 44 ++++
 rtl/rr_arb4.sv | 49 ++++
 rtl/vmem_slot_sched.sv | 145 ++++++++++++++
 tb/tb_vmem_slot_sched.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/vmem_pkg.sv
// Shared definitions for the video memory slot scheduler.
//   - phase_e    : 4-phase memory cycle encoding
//   - src_e      : address source ids (source 0 is display scanout)
//   - SLOT_*     : slot-word bit positions and the idle (nop) word
//   - make_slot_word : builds the slot word for a one-hot grant
package vmem_pkg;

  typedef enum logic [1:0] {
    PHASE_ADDR_SETUP  = 2'd0,
    PHASE_DIR_CHANGE  = 2'd1,
    PHASE_DATA_SETUP  = 2'd2,
    PHASE_DATA_SAMPLE = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    SRC_DISPLAY = 2'd0,
    SRC_1       = 2'd1,
    SRC_2       = 2'd2,
    SRC_3       = 2'd3
  } src_e;

  localparam int unsigned SLOT_RW      = 0;
  localparam int unsigned SLOT_TGT     = 1;
  localparam int unsigned SLOT_SRC_LSB = 2;
  localparam int unsigned SLOT_NOP     = 7;

  localparam logic [7:0] SLOT_NOP_WORD = 8'h80;

  // Empty grant yields the nop word; otherwise encode source, direction and target.
  function automatic logic [7:0] make_slot_word(logic [3:0] gnt, logic [3:0] wr);
    logic [7:0] w;
    logic [1:0] s;
    w = SLOT_NOP_WORD;
    s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) s = 2'(i);
    end
    if (|gnt) begin
      w                      = 8'h00;
      w[SLOT_RW]             = wr[s];
      w[SLOT_TGT]            = (s != SRC_DISPLAY);
      w[SLOT_SRC_LSB +: 2]   = s;
      w[SLOT_NOP]            = 1'b0;
    end
    return w;
  endfunction

endpackage

// File: rtl/vmem_slot_sched_if.sv
// Bus between the slot scheduler and its requesters / configuration master.
//   master : drives Req, ReqWrite, CfgRsvdMask, CfgLoad; observes grant and slot outputs
//   slave  : the scheduler
// With VMEM_SCHED_STATS_EN defined, StatSel/StatClr/StatData are added.
interface vmem_slot_sched_if #(
  parameter int unsigned TSSIZE = 8
);
  localparam int unsigned SlotW = $clog2(TSSIZE);

  logic [3:0]        Req;
  logic [3:0]        ReqWrite;
  logic [3:0]        Gnt;
  logic [TSSIZE-1:0] CfgRsvdMask;
  logic              CfgLoad;
  logic [1:0]        Phase;
  logic [SlotW-1:0]  SlotIndex;
  logic [7:0]        SlotWord;
  logic              FrameStart;

`ifdef VMEM_SCHED_STATS_EN
  logic [1:0]        StatSel;
  logic              StatClr;
  logic [15:0]       StatData;

  modport master (
    output Req, ReqWrite, CfgRsvdMask, CfgLoad, StatSel, StatClr,
    input  Gnt, Phase, SlotIndex, SlotWord, FrameStart, StatData
  );
  modport slave (
    input  Req, ReqWrite, CfgRsvdMask, CfgLoad, StatSel, StatClr,
    output Gnt, Phase, SlotIndex, SlotWord, FrameStart, StatData
  );
`else
  modport master (
    output Req, ReqWrite, CfgRsvdMask, CfgLoad,
    input  Gnt, Phase, SlotIndex, SlotWord, FrameStart
  );
  modport slave (
    input  Req, ReqWrite, CfgRsvdMask, CfgLoad,
    output Gnt, Phase, SlotIndex, SlotWord, FrameStart
  );
`endif

endinterface

// File: rtl/rr_arb4.sv
// 4-way round-robin picker.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : raw requests
//   mask_i       : sources allowed to compete this decision
//   upd_en_i     : move the pointer to the winner (only if something wins)
//   gnt_o        : one-hot winner (combinational), search starts at pointer+1
module rr_arb4 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic [3:0] mask_i,
  input  logic       upd_en_i,
  output logic [3:0] gnt_o
);

  logic [1:0] ptr_d, ptr_q;
  logic [3:0] elig;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;

  assign elig = req_i & mask_i;

  always_comb begin
    gnt_o = 4'b0000;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        gnt_o[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
    ptr_d = (upd_en_i && found) ? win : ptr_q;
  end

  // Pointer resets to 3 so the first search starts at source 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vmem_slot_sched.sv
// Dynamic time-slot scheduler for the video memory phase engine.
// One slot word per 4-phase memory cycle; reserved slots go to source 0 when it
// requests, everything else is round-robin among the four sources.
//   MemClk, Reset : clock, asynchronous active-high reset
//   bus (slave)   : Req/ReqWrite in, Gnt out, CfgRsvdMask/CfgLoad in,
//                   Phase/SlotIndex/SlotWord/FrameStart out
// Optional: define VMEM_SCHED_STATS_EN for per-source saturating grant counters,
// a frame counter and the StatSel/StatClr/StatData read port.
module vmem_slot_sched
  import vmem_pkg::*;
#(
  parameter int unsigned       TSSIZE         = 8,
  parameter logic [TSSIZE-1:0] RSVD_MASK_INIT = 8'b00100101
) (
  input logic              MemClk,
  input logic              Reset,
  vmem_slot_sched_if.slave bus
);

  localparam int unsigned SlotW = $clog2(TSSIZE);

  phase_e            phase_d, phase_q;
  logic [SlotW-1:0]  slot_d, slot_q;
  logic [7:0]        word_d, word_q;
  logic [3:0]        gnt_d, gnt_q;
  logic [TSSIZE-1:0] act_mask_d, act_mask_q;
  logic [TSSIZE-1:0] pend_mask_d, pend_mask_q;
  logic              pend_vld_d, pend_vld_q;

  logic              decide;
  logic [SlotW-1:0]  slot_nxt;
  logic              frame_wrap;
  logic [TSSIZE-1:0] eff_mask;
  logic              rsvd;
  logic              rsvd_hit;
  logic [3:0]        arb_mask;
  logic [3:0]        arb_gnt;
  logic [3:0]        sel_gnt;

  assign decide     = (phase_q == PHASE_DATA_SAMPLE);
  assign slot_nxt   = slot_q + 1'b1;
  assign frame_wrap = (slot_nxt == '0);
  // The decision that produces slot 0 already sees the pending mask.
  assign eff_mask   = (frame_wrap && pend_vld_q) ? pend_mask_q : act_mask_q;
  assign rsvd       = eff_mask[slot_nxt];
  assign rsvd_hit   = rsvd & bus.Req[SRC_DISPLAY];
  // In a reserved slot without a display request, source 0 is excluded.
  assign arb_mask   = rsvd ? 4'b1110 : 4'b1111;
  assign sel_gnt    = rsvd_hit ? 4'b0001 : arb_gnt;

  rr_arb4 u_arb (
    .clk_i    (MemClk),
    .rst_i    (Reset),
    .req_i    (bus.Req),
    .mask_i   (arb_mask),
    .upd_en_i (decide & ~rsvd_hit),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    phase_d     = phase_e'(phase_q + 2'd1);
    slot_d      = slot_q;
    word_d      = word_q;
    gnt_d       = 4'b0000;
    act_mask_d  = act_mask_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;
    if (decide) begin
      slot_d = slot_nxt;
      word_d = make_slot_word(sel_gnt, bus.ReqWrite);
      gnt_d  = sel_gnt;
      if (frame_wrap) begin
        act_mask_d = eff_mask;
        pend_vld_d = 1'b0;
      end
    end
    // Applied after the boundary swap so a load on that edge waits a frame.
    if (bus.CfgLoad) begin
      pend_mask_d = bus.CfgRsvdMask;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge MemClk or posedge Reset) begin
    if (Reset) begin
      phase_q     <= PHASE_ADDR_SETUP;
      slot_q      <= '0;
      word_q      <= SLOT_NOP_WORD;
      gnt_q       <= 4'b0000;
      act_mask_q  <= RSVD_MASK_INIT;
      pend_mask_q <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      slot_q      <= slot_d;
      word_q      <= word_d;
      gnt_q       <= gnt_d;
      act_mask_q  <= act_mask_d;
      pend_mask_q <= pend_mask_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  assign bus.Phase      = phase_q;
  assign bus.SlotIndex  = slot_q;
  assign bus.SlotWord   = word_q;
  assign bus.Gnt        = gnt_q;
  assign bus.FrameStart = (phase_q == PHASE_ADDR_SETUP) && (slot_q == '0);

`ifdef VMEM_SCHED_STATS_EN
  logic [3:0][15:0] gcnt_d, gcnt_q;
  logic [15:0]      frame_cnt_d, frame_cnt_q;
  logic [15:0]      stat_data_d, stat_data_q;

  always_comb begin
    gcnt_d      = gcnt_q;
    frame_cnt_d = frame_cnt_q;
    stat_data_d = gcnt_q[bus.StatSel];
    if (bus.StatClr) begin
      gcnt_d      = '0;
      frame_cnt_d = '0;
    end else if (decide) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_gnt[i] && (gcnt_q[i] != 16'hFFFF)) gcnt_d[i] = gcnt_q[i] + 16'd1;
      end
      if (frame_wrap && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge MemClk or posedge Reset) begin
    if (Reset) begin
      gcnt_q      <= '0;
      frame_cnt_q <= '0;
      stat_data_q <= '0;
    end else begin
      gcnt_q      <= gcnt_d;
      frame_cnt_q <= frame_cnt_d;
      stat_data_q <= stat_data_d;
    end
  end

  assign bus.StatData = stat_data_q;
`endif

endmodule

// File: tb/tb_vmem_slot_sched.sv
// Directed bench for vmem_slot_sched: idle frames, mixed round-robin/reserved
// arbitration, reserved slots falling through to other sources, frame-aligned
// mask reload, asynchronous mid-slot reset and (optionally) grant statistics.
module tb_vmem_slot_sched;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  vmem_slot_sched_if #(.TSSIZE(8)) bus ();

  vmem_slot_sched #(
    .TSSIZE         (8),
    .RSVD_MASK_INIT (8'b00100101)
  ) dut (
    .MemClk (clk),
    .Reset  (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All-requesting, default mask {0,2,5}; slots 1..7,0,1.
  logic [7:0] t2_word [9] = '{8'h00, 8'h00, 8'h06, 8'h0A, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h06};
  logic [3:0] t2_gnt  [9] = '{4'h1, 4'h1, 4'h2, 4'h4, 4'h1, 4'h8, 4'h1, 4'h1, 4'h2};
  // Req=0011, CfgLoad(FF) in slot 3; slots 3..7 then a full reserved frame.
  logic [7:0] t4_word [13] = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h06,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] t4_gnt  [13] = '{4'h1, 4'h2, 4'h1, 4'h1, 4'h2,
                               4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at phase 0 of a slot; leaves at phase 0 of the next slot.
  task automatic chk_slot(input string tag, input int idx, input logic [7:0] word,
                          input logic [3:0] gnt, input bit cfg_pulse);
    check({tag, ".phase"}, bus.Phase, 0);
    check({tag, ".idx"},   bus.SlotIndex, idx);
    check({tag, ".word"},  bus.SlotWord, word);
    check({tag, ".gnt"},   bus.Gnt, gnt);
    if (cfg_pulse) bus.CfgLoad = 1'b1;
    @(negedge clk);
    bus.CfgLoad = 1'b0;
    check({tag, ".gnt_p1"},  bus.Gnt, 0);
    check({tag, ".word_p1"}, bus.SlotWord, word);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, ".phase"}, bus.Phase, 0);
    check({tag, ".idx"},   bus.SlotIndex, 0);
    check({tag, ".word"},  bus.SlotWord, 8'h80);
    check({tag, ".gnt"},   bus.Gnt, 0);
    check({tag, ".fs"},    bus.FrameStart, 1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.Req         = 4'b0000;
    bus.ReqWrite    = 4'b0000;
    bus.CfgRsvdMask = 8'h00;
    bus.CfgLoad     = 1'b0;
`ifdef VMEM_SCHED_STATS_EN
    bus.StatSel     = 2'd0;
    bus.StatClr     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rst = 1'b0;

    // Idle for two frames.
    for (int c = 0; c < 64; c++) begin
      check("idle.phase", bus.Phase, c % 4);
      check("idle.idx",   bus.SlotIndex, (c / 4) % 8);
      check("idle.fs",    bus.FrameStart, (c % 32) == 0);
      check("idle.word",  bus.SlotWord, 8'h80);
      check("idle.gnt",   bus.Gnt, 0);
      @(negedge clk);
    end

    // Everyone requesting, reads only.
    bus.Req = 4'b1111;
    chk_slot("rr", 0, 8'h80, 4'h0, 1'b0);
    for (int i = 0; i < 9; i++) chk_slot("rr", (i + 1) % 8, t2_word[i], t2_gnt[i], 1'b0);

    // Only source 3, writing: reserved slots fall through to it.
    bus.Req      = 4'b1000;
    bus.ReqWrite = 4'b1000;
    chk_slot("s3", 2, 8'h00, 4'h1, 1'b0);
    for (int i = 0; i < 6; i++) chk_slot("s3", (i + 3) % 8, 8'h0F, 4'h8, 1'b0);

    // Mask reload takes effect at the next frame.
    bus.Req         = 4'b0011;
    bus.ReqWrite    = 4'b0000;
    bus.CfgRsvdMask = 8'hFF;
    chk_slot("cfg", 1, 8'h0F, 4'h8, 1'b0);
    chk_slot("cfg", 2, 8'h00, 4'h1, 1'b0);
    for (int i = 0; i < 13; i++) chk_slot("cfg", (i + 3) % 8, t4_word[i], t4_gnt[i], i == 0);

    // Asynchronous reset at phase 2 of slot 5.
    repeat (22) @(negedge clk);
    check("pre_rst.phase", bus.Phase, 2);
    check("pre_rst.idx",   bus.SlotIndex, 5);
    #2 rst = 1'b1;
    #1 chk_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    chk_slot("post_rst", 0, 8'h80, 4'h0, 1'b0);
    chk_slot("post_rst", 1, 8'h00, 4'h1, 1'b0);
    chk_slot("post_rst", 2, 8'h00, 4'h1, 1'b0);
    chk_slot("post_rst", 3, 8'h06, 4'h2, 1'b0);

`ifdef VMEM_SCHED_STATS_EN
    bus.Req = 4'b0000;
    repeat (8) @(negedge clk);
    bus.StatClr = 1'b1;
    @(negedge clk);
    bus.StatClr = 1'b0;
    bus.Req     = 4'b0001;
    repeat (400) @(negedge clk);
    bus.Req = 4'b0000;
    repeat (2) @(negedge clk);
    check("stat.cnt0", bus.StatData, 100);
    bus.StatClr = 1'b1;
    @(negedge clk);
    bus.StatClr = 1'b0;
    @(negedge clk);
    check("stat.clr", bus.StatData, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
